class_vote_argmax: RTL and testbench

CLASS_VOTE_ARGMAX -- requirements
Module: class_vote_argmax

---
 rtl/class_vote_argmax.sv | 160 ++++++++++++++++
 tb/tb_class_vote_argmax.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/class_vote_argmax.sv
// Tree-ensemble vote accumulator: sums per-class votes over the beats of a vector,
// then walks the class counters one per cycle to pick the winner (lowest index on ties).
module class_vote_argmax #(
    parameter int unsigned NUM_CLASSES = 8,
    parameter int unsigned NUM_TREES   = 16,
    localparam int unsigned CW = $clog2(NUM_TREES + 1),
    localparam int unsigned IW = $clog2(NUM_CLASSES)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_CLASSES-1:0] in_votes,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [IW-1:0]          out_class,
    output logic [CW-1:0]          out_count,
    output logic                   out_tie,
    output logic                   out_overflow
);

    typedef enum logic [1:0] {ACCUM, SCAN, HOLD} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q [NUM_CLASSES];
    logic [CW-1:0]   cnt_d [NUM_CLASSES];
    logic [CW-1:0]   beats_q, beats_d;
    logic            ovf_q, ovf_d;
    logic [IW-1:0]   scan_idx_q, scan_idx_d;
    logic [CW-1:0]   best_q, best_d;
    logic [IW-1:0]   best_idx_q, best_idx_d;
    logic            best_tie_q, best_tie_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [IW-1:0]   out_class_q, out_class_d;
    logic [CW-1:0]   out_count_q, out_count_d;
    logic            out_tie_q, out_tie_d;
    logic            out_overflow_q, out_overflow_d;
    logic [CW-1:0]   cur_cnt;

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_class    = out_class_q;
    assign out_count    = out_count_q;
    assign out_tie      = out_tie_q;
    assign out_overflow = out_overflow_q;

    // Next-state, counter and result logic
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        beats_d        = beats_q;
        ovf_d          = ovf_q;
        scan_idx_d     = scan_idx_q;
        best_d         = best_q;
        best_idx_d     = best_idx_q;
        best_tie_d     = best_tie_q;
        out_class_d    = out_class_q;
        out_count_d    = out_count_q;
        out_tie_d      = out_tie_q;
        out_overflow_d = out_overflow_q;
        cur_cnt        = cnt_q[scan_idx_q];

        case (state_q)
            ACCUM: begin
                if (in_valid && in_ready_q) begin
                    for (int k = 0; k < NUM_CLASSES; k++) begin
                        if (in_votes[k] && (cnt_q[k] != CW'(NUM_TREES))) begin
                            cnt_d[k] = cnt_q[k] + CW'(1);
                        end
                    end
                    if (beats_q == CW'(NUM_TREES)) begin
                        ovf_d = 1'b1;
                    end else begin
                        beats_d = beats_q + CW'(1);
                    end
                    if (in_last) begin
                        state_d    = SCAN;
                        scan_idx_d = '0;
                    end
                end
            end
            SCAN: begin
                if (scan_idx_q == '0) begin
                    best_d     = cur_cnt;
                    best_idx_d = '0;
                    best_tie_d = 1'b0;
                end else if (cur_cnt > best_q) begin
                    best_d     = cur_cnt;
                    best_idx_d = scan_idx_q;
                    best_tie_d = 1'b0;
                end else if (cur_cnt == best_q) begin
                    best_tie_d = 1'b1;
                end
                // Publish the result together with the final class step
                if (scan_idx_q == IW'(NUM_CLASSES - 1)) begin
                    state_d        = HOLD;
                    out_class_d    = best_idx_d;
                    out_count_d    = best_d;
                    out_tie_d      = best_tie_d;
                    out_overflow_d = ovf_q;
                end else begin
                    scan_idx_d = scan_idx_q + IW'(1);
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = ACCUM;
                    for (int k = 0; k < NUM_CLASSES; k++) begin
                        cnt_d[k] = '0;
                    end
                    beats_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = ACCUM;
        endcase

        in_ready_d  = (state_d == ACCUM);
        out_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ACCUM;
            for (int k = 0; k < NUM_CLASSES; k++) begin
                cnt_q[k] <= '0;
            end
            beats_q        <= '0;
            ovf_q          <= 1'b0;
            scan_idx_q     <= '0;
            best_q         <= '0;
            best_idx_q     <= '0;
            best_tie_q     <= 1'b0;
            in_ready_q     <= 1'b1;
            out_valid_q    <= 1'b0;
            out_class_q    <= '0;
            out_count_q    <= '0;
            out_tie_q      <= 1'b0;
            out_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            beats_q        <= beats_d;
            ovf_q          <= ovf_d;
            scan_idx_q     <= scan_idx_d;
            best_q         <= best_d;
            best_idx_q     <= best_idx_d;
            best_tie_q     <= best_tie_d;
            in_ready_q     <= in_ready_d;
            out_valid_q    <= out_valid_d;
            out_class_q    <= out_class_d;
            out_count_q    <= out_count_d;
            out_tie_q      <= out_tie_d;
            out_overflow_q <= out_overflow_d;
        end
    end

endmodule

// File: tb/tb_class_vote_argmax.sv
// Directed bench for class_vote_argmax: a reference vote model pushes expected results
// to a scoreboard queue, popped and compared when out_valid appears.
module tb_class_vote_argmax;

    localparam int unsigned NC = 8;
    localparam int unsigned NT = 16;
    localparam int unsigned CW = $clog2(NT + 1);
    localparam int unsigned IW = $clog2(NC);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [NC-1:0] in_votes;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_class;
    logic [CW-1:0] out_count;
    logic          out_tie;
    logic          out_overflow;

    typedef struct packed {
        logic [IW-1:0] cls;
        logic [CW-1:0] cnt;
        logic          tie;
        logic          ovf;
    } res_t;

    res_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned m_cnt[NC];
    int unsigned m_beats;
    logic        m_ovf;

    class_vote_argmax #(.NUM_CLASSES(NC), .NUM_TREES(NT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_votes(in_votes), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_class(out_class), .out_count(out_count), .out_tie(out_tie),
        .out_overflow(out_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < NC; k++) m_cnt[k] = 0;
        m_beats = 0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_push();
        res_t        r;
        int unsigned best;
        int          idx;
        logic        tie;
        best = m_cnt[0];
        idx  = 0;
        for (int k = 1; k < NC; k++) begin
            if (m_cnt[k] > best) begin
                best = m_cnt[k];
                idx  = k;
            end
        end
        tie = 1'b0;
        for (int k = 0; k < NC; k++) begin
            if (k != idx && m_cnt[k] == best) tie = 1'b1;
        end
        r.cls = IW'(idx);
        r.cnt = CW'(best);
        r.tie = tie;
        r.ovf = m_ovf;
        sb.push_back(r);
    endtask

    // Drive one beat (optionally preceded by an idle cycle carrying junk), then release
    task automatic beat(input logic [NC-1:0] v, input logic last, input bit gap);
        if (gap) begin
            in_valid = 1'b0;
            in_votes = NC'($urandom);
            in_last  = 1'($urandom);
            @(negedge clk);
        end
        chk("in_ready_accum", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_votes = v;
        in_last  = last;
        for (int k = 0; k < NC; k++) begin
            if (v[k] && m_cnt[k] < NT) m_cnt[k]++;
        end
        if (m_beats == NT) m_ovf = 1'b1;
        else m_beats++;
        if (last) model_push();
        @(negedge clk);
        in_valid = 1'b0;
        in_votes = NC'($urandom);
        in_last  = 1'b0;
    endtask

    // Wait for the result after the last beat, check it, stall, then hand it off
    task automatic get_result(input int stall);
        int   lat;
        res_t e;
        lat = 1;
        while (!out_valid && lat < 40) begin
            chk("in_ready_scan", 32'(in_ready), 32'd0);
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(NC + 1));
        if (sb.size() == 0) begin
            chk("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            for (int s = 0; s <= stall; s++) begin
                chk("out_valid", 32'(out_valid), 32'd1);
                chk("in_ready_hold", 32'(in_ready), 32'd0);
                chk("out_class", 32'(out_class), 32'(e.cls));
                chk("out_count", 32'(out_count), 32'(e.cnt));
                chk("out_tie", 32'(out_tie), 32'(e.tie));
                chk("out_overflow", 32'(out_overflow), 32'(e.ovf));
                if (s < stall) @(negedge clk);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_after_hs", 32'(out_valid), 32'd0);
        chk("in_ready_after_hs", 32'(in_ready), 32'd1);
        model_clear();
    endtask

    initial begin
        logic [NC-1:0] v;
        int            len;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_votes  = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_class", 32'(out_class), 32'd0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        chk("rst_out_tie", 32'(out_tie), 32'd0);
        chk("rst_out_overflow", 32'(out_overflow), 32'd0);

        // Class 3 in 10 beats, class 5 in 6 beats
        for (int b = 0; b < 16; b++) begin
            v = '0;
            v[3] = (b < 10);
            v[5] = (b < 6);
            beat(v, b == 15, b == 4);
        end
        get_result(0);

        // Classes 2 and 6 tie at 7, class 0 at 3
        for (int b = 0; b < 16; b++) begin
            v = '0;
            v[2] = (b < 7);
            v[6] = (b >= 9);
            v[0] = (b < 3);
            beat(v, b == 15, 1'b0);
        end
        get_result(0);

        // Class 0 wins with 16; hold 5 cycles; next vector exposes any carry-over
        for (int b = 0; b < 16; b++) begin
            v = '0;
            v[0] = 1'b1;
            v[3] = (b < 4);
            beat(v, b == 15, 1'b0);
        end
        get_result(5);
        for (int b = 0; b < 16; b++) beat(NC'(2), b == 15, b == 7);
        get_result(0);

        // 17 all-ones beats: saturation and overflow
        for (int b = 0; b < 17; b++) beat('1, b == 16, 1'b0);
        get_result(0);

        // Single-beat vector, then all-zero vector
        beat(8'b0010_0100, 1'b1, 1'b0);
        get_result(1);
        for (int b = 0; b < 3; b++) beat('0, b == 2, 1'b1);
        get_result(0);

        // Reset pulsed during SCAN discards the pending result
        for (int b = 0; b < 16; b++) beat(NC'(8'h80), b == 15, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midscan_rst_in_ready", 32'(in_ready), 32'd1);
        chk("midscan_rst_out_valid", 32'(out_valid), 32'd0);
        chk("midscan_rst_out_class", 32'(out_class), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        void'(sb.pop_back());
        model_clear();
        for (int c = 0; c < 12; c++) begin
            chk("midscan_no_valid", 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        for (int b = 0; b < 16; b++) begin
            v = '0;
            v[4] = (b < 9);
            v[1] = (b < 2);
            beat(v, b == 15, 1'b0);
        end
        get_result(0);

        // Random vectors of random length with idle gaps
        for (int n = 0; n < 3; n++) begin
            len = $urandom_range(1, 18);
            for (int b = 0; b < len; b++) begin
                beat(NC'($urandom), b == len - 1, 1'($urandom));
            end
            get_result($urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
